// File: rtl/rx_adc_capture_buffer.sv
// Capture RAM behind the RX ADC deserializer: arm, capture DEPTH words, then shift out LSB-first.
// Optional build macro RX_ADC_CAPTURE_PATTERN_EN replaces captured data with a wr_ptr test pattern.
module rx_adc_capture_buffer #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int BIT_W  = 7
) (
  input  logic              rx_adc_mem_clk,
  input  logic              RX_ADC_RST_ACTHIGH,
  input  logic              RX_ADC_MEM_WRITE_EN,
  input  logic [WIDTH-1:0]  rx_adc_word_in,
  input  logic              rx_adc_word_valid,
  input  logic              RX_ADC_SCAN_EN,
  input  logic              RX_ADC_SCAN_IN,
  output logic              RX_ADC_DIG_OUT,
  output logic              rx_adc_cap_busy,
  output logic              rx_adc_cap_done,
  output logic              rx_adc_cap_ovf,
  output logic [ADDR_W:0]   rx_adc_wr_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  logic [1:0]        r_state;
  logic              r_arm_d;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0]  r_sreg;
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_dig_out;
  logic              r_done;
  logic              r_ovf;
  logic [ADDR_W:0]   r_wr_count;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_arm_rise;
  logic              w_wr_en;
  logic [WIDTH-1:0]  w_wr_data;

  assign w_arm_rise = RX_ADC_MEM_WRITE_EN & ~r_arm_d;
  // Abort (arm low) wins over a same-cycle valid word.
  assign w_wr_en    = (r_state == S_CAPTURE) & RX_ADC_MEM_WRITE_EN & rx_adc_word_valid;

`ifdef RX_ADC_CAPTURE_PATTERN_EN
  localparam int REP = (WIDTH + ADDR_W - 1) / ADDR_W;
  logic [REP*ADDR_W-1:0] w_pattern;
  logic                  w_unused_word;
  assign w_pattern     = {REP{r_wr_ptr}};
  assign w_wr_data     = w_pattern[WIDTH-1:0];
  assign w_unused_word = ^rx_adc_word_in;
`else
  assign w_wr_data = rx_adc_word_in;
`endif

  // RAM is not reset; read port runs every cycle with one cycle of latency.
  always_ff @(posedge rx_adc_mem_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
    r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge rx_adc_mem_clk) begin
    if (RX_ADC_RST_ACTHIGH) begin
      r_state    <= S_IDLE;
      r_arm_d    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_bit_cnt  <= '0;
      r_sreg     <= '0;
      r_dig_out  <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_arm_d <= RX_ADC_MEM_WRITE_EN;
      if (w_arm_rise && r_state != S_IDLE) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_arm_rise) begin
            r_state    <= S_CAPTURE;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_done     <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (!RX_ADC_MEM_WRITE_EN) begin
            r_state <= S_IDLE;
          end else if (rx_adc_word_valid) begin
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
            if (r_wr_ptr == ADDR_W'(DEPTH-1)) begin
              r_state  <= S_LOAD;
              r_done   <= 1'b1;
              r_rd_ptr <= '0;
            end
          end
        end
        S_LOAD: begin
          r_sreg    <= r_rd_data;
          r_rd_ptr  <= ADDR_W'(1);
          r_bit_cnt <= '0;
          r_state   <= S_READOUT;
        end
        S_READOUT: begin
          if (RX_ADC_SCAN_EN) begin
            r_dig_out <= r_sreg[0];
            if (r_bit_cnt == BIT_W'(WIDTH-1)) begin
              // rd_ptr already names the next word; it reads 0 once the last word is in sreg.
              r_sreg    <= r_rd_data;
              r_bit_cnt <= '0;
              if (r_rd_ptr == '0) r_state  <= S_IDLE;
              else                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end else begin
              r_sreg    <= {RX_ADC_SCAN_IN, r_sreg[WIDTH-1:1]};
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RX_ADC_DIG_OUT  = r_dig_out;
  assign rx_adc_cap_busy = (r_state == S_CAPTURE);
  assign rx_adc_cap_done = r_done;
  assign rx_adc_cap_ovf  = r_ovf;
  assign rx_adc_wr_count = r_wr_count;

endmodule
